data_memory_ctrl: RTL and testbench

- Next-generation data memory for the MIPS datapath, replacing the fixed word-only RAM.
- Adds byte/half/word stores and loads with sign or zero extension, a registered read path and a configurable wait-state latency.
- Uses a req/ready handshake so the control unit can stall the pipeline.
- Flags misaligned accesses instead of performing them.

---
 rtl/data_memory_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
// Data memory for the MIPS datapath: byte/half/word loads and stores with a
// req/ready handshake, optional wait states, registered read data and misalignment flagging.
module data_memory_ctrl #(
   parameter int ADDR_WIDTH  = 6,
   parameter int WAIT_STATES = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req,
   input  logic                  we,
   input  logic [1:0]            size,
   input  logic                  uns,
   input  logic [ADDR_WIDTH+1:0] addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata,
   output logic                  ready,
   output logic                  err,
   output logic                  busy
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lane);
      logic bad;
      case (sz)
         2'b00:   bad = 1'b0;
         2'b01:   bad = lane[0];
         2'b10:   bad = (lane != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   function automatic logic [3:0] byte_enables(input logic [1:0] sz, input logic [1:0] lane);
      logic [3:0] be;
      case (sz)
         2'b00:   be = 4'b0001 << lane;
         2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
         2'b10:   be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] sz,
                                               input logic [1:0] lane, input logic zext);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] v;
      b = word[{lane, 3'b000} +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (sz)
         2'b00:   v = zext ? {24'h000000, b} : {{24{b[7]}}, b};
         2'b01:   v = zext ? {16'h0000, h} : {{16{h[15]}}, h};
         default: v = word;
      endcase
      return v;
   endfunction

   state_t                  state_r;
   state_t                  next_state_s;
   logic                    we_r;
   logic                    uns_r;
   logic [1:0]              size_r;
   logic [ADDR_WIDTH+1:0]   addr_r;
   logic [31:0]             wdata_r;
   logic [3:0]              cnt_r;
   logic [31:0]             rdata_r;
   logic                    ready_r;
   logic                    err_r;
   logic                    accept_s;
   logic                    access_s;
   logic                    ready_next_s;
   logic                    err_next_s;
   logic [ADDR_WIDTH-1:0]   idx_s;
   logic [1:0]              lane_s;
   logic [3:0]              be_s;
   logic [31:0]             wlanes_s;
   logic [31:0]             mem_word_s;
   logic [31:0]             mem_r [DEPTH];

   // A request is taken in IDLE, or on the edge leaving DONE so held req streams without a gap.
   assign accept_s   = req && ((state_r == IDLE) || (state_r == DONE));
   assign access_s   = (state_r == WAIT) && (cnt_r == 4'd0);
   assign idx_s      = addr_r[ADDR_WIDTH+1:2];
   assign lane_s     = addr_r[1:0];
   assign be_s       = byte_enables(size_r, lane_s);
   assign mem_word_s = mem_r[idx_s];

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE, DONE: begin
            if (accept_s) begin
               next_state_s = misaligned(size, addr[1:0]) ? DONE : WAIT;
            end else begin
               next_state_s = IDLE;
            end
         end
         WAIT: begin
            if (cnt_r == 4'd0) begin
               next_state_s = DONE;
            end else begin
               next_state_s = WAIT;
            end
         end
         default: next_state_s = IDLE;
      endcase
   end

   // Output decode; entering DONE straight from an accept means the request was rejected.
   always_comb begin
      ready_next_s = (next_state_s == DONE);
      err_next_s   = (next_state_s == DONE) && accept_s;
   end

   // Request capture and wait-state counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_r    <= 1'b0;
         uns_r   <= 1'b0;
         size_r  <= 2'b00;
         addr_r  <= '0;
         wdata_r <= 32'h00000000;
         cnt_r   <= 4'd0;
      end else if (accept_s) begin
         we_r    <= we;
         uns_r   <= uns;
         size_r  <= size;
         addr_r  <= addr;
         wdata_r <= wdata;
         cnt_r   <= 4'(WAIT_STATES);
      end else if ((state_r == WAIT) && (cnt_r != 4'd0)) begin
         cnt_r <= cnt_r - 4'd1;
      end
   end

   // Replicate store data across lanes so the byte enables pick the right copy.
   always_comb begin
      wlanes_s = wdata_r;
      case (size_r)
         2'b00:   wlanes_s = {4{wdata_r[7:0]}};
         2'b01:   wlanes_s = {2{wdata_r[15:0]}};
         default: wlanes_s = wdata_r;
      endcase
   end

   // Storage array; not reset, and writes only from WAIT which reset leaves immediately.
   always_ff @(posedge clk) begin
      if (access_s && we_r) begin
         for (int i = 0; i < 4; i++) begin
            if (be_s[i]) begin
               mem_r[idx_s][i*8 +: 8] <= wlanes_s[i*8 +: 8];
            end
         end
      end
   end

   // Registered handshake outputs and load data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_r <= 32'h00000000;
         ready_r <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         ready_r <= ready_next_s;
         err_r   <= err_next_s;
         if (access_s && !we_r) begin
            rdata_r <= extend_load(mem_word_s, size_r, lane_s, uns_r);
         end
      end
   end

   assign rdata = rdata_r;
   assign ready = ready_r;
   assign err   = err_r;
   assign busy  = (state_r != IDLE);

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: two instances (0 and 3 wait states) share stimulus and
// are compared against an arithmetic model of the memory and rdata register.
module tb_data_memory_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0 = 1'b0, req3 = 1'b0, we = 1'b0, uns = 1'b0;
   logic [1:0]  size = 2'b00;
   logic [7:0]  addr = 8'h00;
   logic [31:0] wdata = 32'h0;
   logic [31:0] rdata0, rdata3;
   logic        ready0, ready3, err0, err3, busy0, busy3;

   int          passes = 0;
   int          total = 0;
   logic [31:0] model [64];
   logic [31:0] exp_rdata = 32'h0;

   data_memory_ctrl #(.ADDR_WIDTH(6), .WAIT_STATES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .req(req0), .we(we), .size(size), .uns(uns), .addr(addr),
      .wdata(wdata), .rdata(rdata0), .ready(ready0), .err(err0), .busy(busy0));

   data_memory_ctrl #(.ADDR_WIDTH(6), .WAIT_STATES(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .req(req3), .we(we), .size(size), .uns(uns), .addr(addr),
      .wdata(wdata), .rdata(rdata3), .ready(ready3), .err(err3), .busy(busy3));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
   endtask

   function automatic bit is_bad(input logic [1:0] sz, input logic [1:0] lane);
      return (sz == 2'd3) || (sz == 2'd1 && lane % 2 == 1) || (sz == 2'd2 && lane != 2'd0);
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] sz,
                                              input int lane, input logic u);
      logic [31:0] v;
      if (sz == 2'd0) begin
         v = (word >> (8 * lane)) & 32'hff;
         if (!u && v >= 32'h80) v = v + 32'hffffff00;
      end else if (sz == 2'd1) begin
         v = (word >> (16 * (lane / 2))) & 32'hffff;
         if (!u && v >= 32'h8000) v = v + 32'hffff0000;
      end else begin
         v = word;
      end
      return v;
   endfunction

   function automatic logic [31:0] model_store(input logic [31:0] old, input logic [1:0] sz,
                                               input int lane, input logic [31:0] wd);
      logic [31:0] mask, data;
      if (sz == 2'd0) begin
         mask = 32'hff << (8 * lane);
         data = (wd & 32'hff) << (8 * lane);
      end else if (sz == 2'd1) begin
         mask = 32'hffff << (16 * (lane / 2));
         data = (wd & 32'hffff) << (16 * (lane / 2));
      end else begin
         mask = 32'hffffffff;
         data = wd;
      end
      return (old & ~mask) | (data & mask);
   endfunction

   // One request presented to both instances; watches 8 cycles after acceptance.
   task automatic do_op(input logic w, input logic [1:0] sz, input logic u, input logic [7:0] a,
                        input logic [31:0] wd, input string tag, input bit pulse);
      bit          bad;
      int          k0 = 0, k3 = 0, n0 = 0, n3 = 0, b0 = 0, b3 = 0, stray = 0;
      logic [31:0] r0 = 32'h0, r3 = 32'h0;
      logic        e0 = 1'b0, e3 = 1'b0;
      bad = is_bad(sz, a[1:0]);
      @(negedge clk);
      req0 = 1'b1; req3 = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = wd;
      @(negedge clk);
      req0 = 1'b0; req3 = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         if (ready0) begin n0++; if (k0 == 0) begin k0 = k; r0 = rdata0; e0 = err0; end end
         if (ready3) begin n3++; if (k3 == 0) begin k3 = k; r3 = rdata3; e3 = err3; end end
         if (busy0) b0++;
         if (busy3) b3++;
         if ((!ready0 && err0) || (!ready3 && err3)) stray++;
         if (pulse && k == 2) req3 = 1'b1;
         if (pulse && k == 3) req3 = 1'b0;
         @(negedge clk);
      end
      if (!bad) begin
         if (w) model[a[7:2]] = model_store(model[a[7:2]], sz, int'(a[1:0]), wd);
         else exp_rdata = model_load(model[a[7:2]], sz, int'(a[1:0]), u);
      end
      check({tag, " lat0"}, 32'(k0), bad ? 32'd1 : 32'd2);
      check({tag, " lat3"}, 32'(k3), bad ? 32'd1 : 32'd5);
      check({tag, " pulses0"}, 32'(n0), 32'd1);
      check({tag, " pulses3"}, 32'(n3), 32'd1);
      check({tag, " busy0"}, 32'(b0), bad ? 32'd1 : 32'd2);
      check({tag, " busy3"}, 32'(b3), bad ? 32'd1 : 32'd5);
      check({tag, " rdata0"}, r0, exp_rdata);
      check({tag, " rdata3"}, r3, exp_rdata);
      check({tag, " err0"}, 32'(e0), 32'(bad));
      check({tag, " err3"}, 32'(e3), 32'(bad));
      check({tag, " err_idle"}, 32'(stray), 32'd0);
   endtask

   initial begin
      int          n, b, b3c, rmask;
      logic [7:0]  ra;

      @(negedge clk);
      check("rst ready", {30'd0, ready0, ready3}, 32'd0);
      check("rst busy", {30'd0, busy0, busy3}, 32'd0);
      check("rst err", {30'd0, err0, err3}, 32'd0);
      check("rst rdata0", rdata0, 32'd0);
      check("rst rdata3", rdata3, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 64; i++) do_op(1'b1, 2'd2, 1'b0, 8'(i * 4), $urandom, "init", 1'b0);

      do_op(1'b1, 2'd2, 1'b0, 8'h10, 32'h8badf00d, "sw10", 1'b0);
      do_op(1'b0, 2'd2, 1'b0, 8'h10, 32'h0, "lw10", 1'b0);

      // Held req on the 0-wait instance: two loads back to back with no idle cycle.
      n = 0; b = 0; b3c = 0; rmask = 0;
      @(negedge clk);
      req0 = 1'b1; we = 1'b0; size = 2'd2; uns = 1'b0; addr = 8'h10;
      @(negedge clk);
      for (int k = 1; k <= 6; k++) begin
         if (ready0) begin n++; rmask = rmask | (1 << k); end
         if (busy0) b++;
         if (busy3) b3c++;
         if (k == 3) req0 = 1'b0;
         @(negedge clk);
      end
      check("b2b ready_cycles", 32'(rmask), 32'h14);
      check("b2b pulses", 32'(n), 32'd2);
      check("b2b busy", 32'(b), 32'd4);
      check("b2b other_idle", 32'(b3c), 32'd0);
      check("b2b rdata", rdata0, exp_rdata);

      do_op(1'b1, 2'd2, 1'b0, 8'h20, 32'h0, "sw20", 1'b0);
      do_op(1'b1, 2'd0, 1'b0, 8'h21, 32'h80, "sb21", 1'b0);
      do_op(1'b0, 2'd0, 1'b0, 8'h21, 32'h0, "lb21", 1'b0);
      do_op(1'b0, 2'd0, 1'b1, 8'h21, 32'h0, "lbu21", 1'b0);
      do_op(1'b0, 2'd2, 1'b0, 8'h20, 32'h0, "lw20", 1'b0);
      do_op(1'b1, 2'd2, 1'b0, 8'h30, 32'h0, "sw30", 1'b0);
      do_op(1'b1, 2'd1, 1'b0, 8'h32, 32'hbeef, "sh32", 1'b0);
      do_op(1'b0, 2'd1, 1'b0, 8'h32, 32'h0, "lh32", 1'b0);
      do_op(1'b0, 2'd1, 1'b1, 8'h32, 32'h0, "lhu32", 1'b0);
      do_op(1'b0, 2'd2, 1'b0, 8'h30, 32'h0, "lw30", 1'b0);
      do_op(1'b0, 2'd1, 1'b0, 8'h33, 32'h0, "lh33", 1'b0);
      do_op(1'b0, 2'd2, 1'b0, 8'h02, 32'h0, "lw02", 1'b0);
      do_op(1'b0, 2'd3, 1'b0, 8'h20, 32'h0, "sz11", 1'b0);
      do_op(1'b1, 2'd2, 1'b0, 8'h41, 32'hffffffff, "sw41", 1'b0);
      do_op(1'b0, 2'd2, 1'b0, 8'h40, 32'h0, "lw40", 1'b0);
      do_op(1'b0, 2'd2, 1'b0, 8'h30, 32'h0, "lwpulse", 1'b1);

      // Reset while both instances sit in WAIT of a store: it must be abandoned.
      @(negedge clk);
      req0 = 1'b1; req3 = 1'b1; we = 1'b1; size = 2'd2; addr = 8'h40; wdata = 32'h12345678;
      @(negedge clk);
      req0 = 1'b0; req3 = 1'b0;
      check("mid busy3", 32'(busy3), 32'd1);
      rst_n = 1'b0;
      #1;
      exp_rdata = 32'h0;
      check("mid_rst ready", {30'd0, ready0, ready3}, 32'd0);
      check("mid_rst busy", {30'd0, busy0, busy3}, 32'd0);
      check("mid_rst err", {30'd0, err0, err3}, 32'd0);
      check("mid_rst rdata0", rdata0, 32'd0);
      check("mid_rst rdata3", rdata3, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      do_op(1'b0, 2'd2, 1'b0, 8'h40, 32'h0, "lw40_after_rst", 1'b0);

      for (int i = 0; i < 120; i++) begin
         ra = 8'($urandom_range(0, 255));
         do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               ra, $urandom, "rand", 1'b0);
      end

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
